riscv_hazard_mc: RTL and testbench

Next-generation hazard and forwarding unit for the 5-stage pipelined RISC-V core, replacing the single-cycle-execute hazard logic. It keeps the existing duties: E-stage forwarding, load-use stall and branch/jump flush. It adds a scoreboarded multi-cycle execute path (divider/multiplier) with a bounded-latency FSM, an E-stage hold with M-stage bubble insertion, and a no-forwarding build mode. It sits beside the decode and execute stages and drives every stall and flush in the core top.

---
 rtl/riscv_hazard_mc_pkg.sv | 17 +
 rtl/riscv_hazard_mc_tracker.sv | 76 +++++++
 rtl/riscv_hazard_mc.sv | 119 +++++++++++
 tb/tb_riscv_hazard_mc.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_mc_pkg.sv
// Shared encodings for the hazard unit and its multi-cycle tracker.
package riscv_hazard_mc_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // Forward-select encodings for the E-stage operand muxes
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Result-source encoding marking a load in E
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/riscv_hazard_mc_tracker.sv
// Multi-cycle execute tracker: IDLE/BUSY FSM with a bounded latency counter.
// o_hold asks the top to freeze F/D/E and bubble M; o_timeout is sticky until reset.
module riscv_mc_tracker
    import riscv_hazard_mc_pkg::*;
#(
    parameter int MC_MAX_LAT = 34
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mc_e,
    input  logic i_mc_done,
    output logic o_busy,
    output logic o_hold,
    output logic o_timeout
);

    localparam int CW = $clog2(MC_MAX_LAT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MC_MAX_LAT);

    mc_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          start;

    // An op that does not finish in its first E cycle needs the pipeline held
    assign start = i_mc_e & ~i_mc_done;

    // Hold request: entering BUSY, or still waiting below the latency bound
    always_comb begin
        o_hold = 1'b0;
        unique case (state_q)
            MC_IDLE: o_hold = start;
            MC_BUSY: o_hold = ~i_mc_done & (cnt_q < CNT_MAX);
            default: o_hold = 1'b0;
        endcase
    end

    // State, latency counter and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= MC_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                MC_IDLE: begin
                    if (start) begin
                        state_q <= MC_BUSY;
                        cnt_q   <= CW'(1);
                    end
                end
                MC_BUSY: begin
                    if (i_mc_done) begin
                        state_q <= MC_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Unit never answered: release the pipeline and flag it
                        timeout_q <= 1'b1;
                        state_q   <= MC_IDLE;
                        cnt_q     <= '0;
                    end
                end
                default: begin
                    state_q <= MC_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_busy    = (state_q == MC_BUSY);
    assign o_timeout = timeout_q;

endmodule

// File: rtl/riscv_hazard_mc.sv
// Hazard and forwarding unit for the 5-stage core with a multi-cycle execute path.
// All stall/flush/forward outputs are combinational; only the tracker holds state.
module riscv_hazard_mc
    import riscv_hazard_mc_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_MAX_LAT = 34,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_rs_1d,
    input  logic [REG_AW-1:0] i_rs_2d,
    input  logic [REG_AW-1:0] i_rs_1e,
    input  logic [REG_AW-1:0] i_rs_2e,
    input  logic [REG_AW-1:0] i_rd_e,
    input  logic              i_reg_write_e,
    input  logic [1:0]        i_result_src_e,
    input  logic              i_mc_e,
    input  logic              i_mc_done,
    input  logic              i_pc_src_e,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_m,
    input  logic              i_reg_write_w,
    output logic              o_stall_f,
    output logic              o_stall_d,
    output logic              o_stall_e,
    output logic              o_flush_d,
    output logic              o_flush_e,
    output logic              o_flush_m,
    output logic [1:0]        o_forward_ae,
    output logic [1:0]        o_forward_be,
    output logic              o_mc_busy,
    output logic              o_mc_timeout
);

    logic mc_hold;
    logic load_use;
    logic raw_hazard;

    // x0 is hardwired to zero, so it never creates a dependency
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic              we,
                                     input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] rd_w,
                                           input logic              we_w);
        if (reg_hit(rd_m, we_m, rs)) return FWD_M;
        if (reg_hit(rd_w, we_w, rs)) return FWD_W;
        return FWD_RF;
    endfunction

    riscv_mc_tracker #(
        .MC_MAX_LAT (MC_MAX_LAT)
    ) u_tracker (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_mc_e    (i_mc_e),
        .i_mc_done (i_mc_done),
        .o_busy    (o_mc_busy),
        .o_hold    (mc_hold),
        .o_timeout (o_mc_timeout)
    );

    assign load_use = (i_result_src_e == RESULT_SRC_LOAD) &
                      (reg_hit(i_rd_e, i_reg_write_e, i_rs_1d) |
                       reg_hit(i_rd_e, i_reg_write_e, i_rs_2d));

    // Without forwarding every in-flight writer of a D source must drain first
    assign raw_hazard = FWD_EN ? 1'b0 :
                        (reg_hit(i_rd_e, i_reg_write_e, i_rs_1d) |
                         reg_hit(i_rd_e, i_reg_write_e, i_rs_2d) |
                         reg_hit(i_rd_m, i_reg_write_m, i_rs_1d) |
                         reg_hit(i_rd_m, i_reg_write_m, i_rs_2d) |
                         reg_hit(i_rd_w, i_reg_write_w, i_rs_1d) |
                         reg_hit(i_rd_w, i_reg_write_w, i_rs_2d));

    // Prioritised stall/flush/forward resolution: reset > mc hold > redirect > dependency
    always_comb begin
        o_stall_f    = 1'b0;
        o_stall_d    = 1'b0;
        o_stall_e    = 1'b0;
        o_flush_d    = 1'b0;
        o_flush_e    = 1'b0;
        o_flush_m    = 1'b0;
        o_forward_ae = FWD_RF;
        o_forward_be = FWD_RF;
        if (i_rst) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
            o_flush_m = 1'b1;
        end else begin
            if (FWD_EN) begin
                o_forward_ae = fwd_sel(i_rs_1e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
                o_forward_be = fwd_sel(i_rs_2e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
            end
            if (mc_hold) begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_stall_e = 1'b1;
                o_flush_m = 1'b1;
            end else if (i_pc_src_e) begin
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
            end else if (load_use | raw_hazard) begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_flush_e = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_hazard_mc.sv
// Bench for riscv_hazard_mc: instance A (forwarding, MC_MAX_LAT=34) and
// instance B (no forwarding, MC_MAX_LAT=4) share one set of inputs.
module tb_riscv_hazard_mc;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       rwe;
        logic [1:0] rse;
        logic       mce, done, pc;
        logic [4:0] rdm, rdw;
        logic       rwm, rww;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, fd, fe, fm;
        logic [1:0] fa, fb;
        logic       busy, tmo;
    } out_t;

    typedef struct packed {
        in_t        v;
        out_t       ea;
        logic       b_st;
        logic       b_fe;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [4:0] rs_1d, rs_2d, rs_1e, rs_2e, rd_e, rd_m, rd_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic [1:0] result_src_e;
    logic       mc_e, mc_done, pc_src_e;

    logic       a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy, a_tmo;
    logic [1:0] a_fa, a_fb;
    logic       b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy, b_tmo;
    logic [1:0] b_fa, b_fb;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, per instance: op in flight, its start cycle, sticky timeout
    bit act_m[2];
    int start_m[2];
    bit tmo_m[2];
    int maxl_m[2];
    bit fwd_m[2];
    int cyc = 0;

    riscv_hazard_mc #(.REG_AW(5), .MC_MAX_LAT(34), .FWD_EN(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_rs_1d(rs_1d), .i_rs_2d(rs_2d), .i_rs_1e(rs_1e), .i_rs_2e(rs_2e), .i_rd_e(rd_e),
        .i_reg_write_e(reg_write_e), .i_result_src_e(result_src_e),
        .i_mc_e(mc_e), .i_mc_done(mc_done), .i_pc_src_e(pc_src_e),
        .i_rd_m(rd_m), .i_rd_w(rd_w), .i_reg_write_m(reg_write_m), .i_reg_write_w(reg_write_w),
        .o_stall_f(a_sf), .o_stall_d(a_sd), .o_stall_e(a_se),
        .o_flush_d(a_fd), .o_flush_e(a_fe), .o_flush_m(a_fm),
        .o_forward_ae(a_fa), .o_forward_be(a_fb),
        .o_mc_busy(a_busy), .o_mc_timeout(a_tmo)
    );

    riscv_hazard_mc #(.REG_AW(5), .MC_MAX_LAT(4), .FWD_EN(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_rs_1d(rs_1d), .i_rs_2d(rs_2d), .i_rs_1e(rs_1e), .i_rs_2e(rs_2e), .i_rd_e(rd_e),
        .i_reg_write_e(reg_write_e), .i_result_src_e(result_src_e),
        .i_mc_e(mc_e), .i_mc_done(mc_done), .i_pc_src_e(pc_src_e),
        .i_rd_m(rd_m), .i_rd_w(rd_w), .i_reg_write_m(reg_write_m), .i_reg_write_w(reg_write_w),
        .o_stall_f(b_sf), .o_stall_d(b_sd), .o_stall_e(b_se),
        .o_flush_d(b_fd), .o_flush_e(b_fe), .o_flush_m(b_fm),
        .o_forward_ae(b_fa), .o_forward_be(b_fb),
        .o_mc_busy(b_busy), .o_mc_timeout(b_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic out_t get_out(input int which);
        out_t o;
        if (which == 0) o = '{a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb, a_busy, a_tmo};
        else            o = '{b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_fa, b_fb, b_busy, b_tmo};
        return o;
    endfunction

    task automatic chk_out(input string p, input out_t act, input out_t exp);
        chk({p, ".stall_f"},   8'(act.sf),   8'(exp.sf));
        chk({p, ".stall_d"},   8'(act.sd),   8'(exp.sd));
        chk({p, ".stall_e"},   8'(act.se),   8'(exp.se));
        chk({p, ".flush_d"},   8'(act.fd),   8'(exp.fd));
        chk({p, ".flush_e"},   8'(act.fe),   8'(exp.fe));
        chk({p, ".flush_m"},   8'(act.fm),   8'(exp.fm));
        chk({p, ".fwd_ae"},    8'(act.fa),   8'(exp.fa));
        chk({p, ".fwd_be"},    8'(act.fb),   8'(exp.fb));
        chk({p, ".mc_busy"},   8'(act.busy), 8'(exp.busy));
        chk({p, ".mc_timeout"},8'(act.tmo),  8'(exp.tmo));
    endtask

    task automatic apply(input in_t v);
        rst = v.rst;  rs_1d = v.rs1d; rs_2d = v.rs2d; rs_1e = v.rs1e; rs_2e = v.rs2e;
        rd_e = v.rde; reg_write_e = v.rwe; result_src_e = v.rse;
        mc_e = v.mce; mc_done = v.done; pc_src_e = v.pc;
        rd_m = v.rdm; rd_w = v.rdw; reg_write_m = v.rwm; reg_write_w = v.rww;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t mk(input bit sf, sd, se, fd, fe, fm, input int fa, fb);
        out_t o;
        o = '{sf, sd, se, fd, fe, fm, 2'(fa), 2'(fb), 1'b0, 1'b0};
        return o;
    endfunction

    // Writer rd produces a value that reader rs depends on
    function automatic bit hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && rd != 5'd0 && rd == rs;
    endfunction

    function automatic out_t model_eval(input in_t v, input int k);
        out_t o;
        bit hold, lu, raw;
        int waited;
        o = '0;
        waited = cyc - start_m[k];
        if (act_m[k]) hold = !v.done && waited < maxl_m[k];
        else          hold = v.mce && !v.done;
        lu = v.rse == 2'b01 && (hit(v.rde, v.rwe, v.rs1d) || hit(v.rde, v.rwe, v.rs2d));
        raw = 1'b0;
        if (!fwd_m[k]) begin
            logic [4:0] srcs[2];
            srcs[0] = v.rs1d;
            srcs[1] = v.rs2d;
            for (int s = 0; s < 2; s++)
                raw = raw || hit(v.rde, v.rwe, srcs[s]) || hit(v.rdm, v.rwm, srcs[s])
                          || hit(v.rdw, v.rww, srcs[s]);
        end
        if (v.rst) begin
            o.fd = 1; o.fe = 1; o.fm = 1;
        end else begin
            if (fwd_m[k]) begin
                o.fa = hit(v.rdm, v.rwm, v.rs1e) ? 2'b10 : hit(v.rdw, v.rww, v.rs1e) ? 2'b01 : 2'b00;
                o.fb = hit(v.rdm, v.rwm, v.rs2e) ? 2'b10 : hit(v.rdw, v.rww, v.rs2e) ? 2'b01 : 2'b00;
            end
            if (hold) begin
                o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1;
            end else if (v.pc) begin
                o.fd = 1; o.fe = 1;
            end else if (lu || raw) begin
                o.sf = 1; o.sd = 1; o.fe = 1;
            end
        end
        o.busy = act_m[k];
        o.tmo  = tmo_m[k];
        return o;
    endfunction

    task automatic model_step(input in_t v);
        for (int k = 0; k < 2; k++) begin
            if (v.rst) begin
                act_m[k] = 0;
                tmo_m[k] = 0;
            end else if (!act_m[k]) begin
                if (v.mce && !v.done) begin
                    act_m[k]   = 1;
                    start_m[k] = cyc;
                end
            end else if (v.done) begin
                act_m[k] = 0;
            end else if (cyc - start_m[k] >= maxl_m[k]) begin
                act_m[k] = 0;
                tmo_m[k] = 1;
            end
        end
        cyc++;
    endtask

    initial begin
        rec_t tbl[12];
        in_t  z, v;
        z = '0;
        maxl_m[0] = 34; maxl_m[1] = 4;
        fwd_m[0]  = 1;  fwd_m[1]  = 0;

        // Directed single-cycle vectors (FSM idle)
        for (int i = 0; i < 12; i++) begin
            tbl[i].v = z; tbl[i].ea = mk(0,0,0,0,0,0,0,0); tbl[i].b_st = 0; tbl[i].b_fe = 0;
        end
        tbl[0].v.rwm = 1; tbl[0].v.rdm = 5; tbl[0].v.rww = 1; tbl[0].v.rdw = 5; tbl[0].v.rs1e = 5;
        tbl[0].ea = mk(0,0,0,0,0,0,2,0);
        tbl[1].v.rww = 1; tbl[1].v.rdw = 5; tbl[1].v.rs1e = 5;
        tbl[1].ea = mk(0,0,0,0,0,0,1,0);
        tbl[2].v.rwm = 1; tbl[2].v.rww = 1;
        tbl[3].v.rs1e = 7; tbl[3].v.rdw = 7; tbl[3].v.rww = 1;
        tbl[3].v.rs2e = 6; tbl[3].v.rdm = 6; tbl[3].v.rwm = 1;
        tbl[3].ea = mk(0,0,0,0,0,0,1,2);
        tbl[4].v.rse = 2'b01; tbl[4].v.rwe = 1; tbl[4].v.rde = 3; tbl[4].v.rs1d = 3;
        tbl[4].ea = mk(1,1,0,0,1,0,0,0); tbl[4].b_st = 1; tbl[4].b_fe = 1;
        tbl[5].v.rse = 2'b01; tbl[5].v.rwe = 1; tbl[5].v.rde = 3; tbl[5].v.rs2d = 3; tbl[5].v.rs1d = 4;
        tbl[5].ea = mk(1,1,0,0,1,0,0,0); tbl[5].b_st = 1; tbl[5].b_fe = 1;
        tbl[6].v.rse = 2'b01; tbl[6].v.rwe = 1;
        tbl[7].v.rwe = 1; tbl[7].v.rde = 3; tbl[7].v.rs1d = 3;
        tbl[7].b_st = 1; tbl[7].b_fe = 1;
        tbl[8].v = tbl[4].v; tbl[8].v.pc = 1;
        tbl[8].ea = mk(0,0,0,1,1,0,0,0); tbl[8].b_fe = 1;
        tbl[9].v.rwm = 1; tbl[9].v.rdm = 7; tbl[9].v.rs1d = 7;
        tbl[9].b_st = 1; tbl[9].b_fe = 1;
        tbl[10].v = tbl[4].v; tbl[10].v.rst = 1; tbl[10].v.rwm = 1; tbl[10].v.rdm = 5; tbl[10].v.rs1e = 5;
        tbl[10].ea = mk(0,0,0,1,1,1,0,0); tbl[10].b_fe = 1;
        tbl[11].v.rww = 1; tbl[11].v.rdw = 7; tbl[11].v.rs2d = 7;
        tbl[11].v.rse = 2'b01; tbl[11].v.rde = 7;
        tbl[11].b_st = 1; tbl[11].b_fe = 1;

        v = z; v.rst = 1;
        apply(v); adv(); adv();
        v.rst = 0; apply(v);
        settle();
        chk_out("reset.a", get_out(0), mk(0,0,0,0,0,0,0,0));
        adv();

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].v);
            settle();
            chk_out($sformatf("vec%0d.a", i), get_out(0), tbl[i].ea);
            chk($sformatf("vec%0d.b.stall_f", i), 8'(b_sf), 8'(tbl[i].b_st));
            chk($sformatf("vec%0d.b.stall_d", i), 8'(b_sd), 8'(tbl[i].b_st));
            chk($sformatf("vec%0d.b.flush_e", i), 8'(b_fe), 8'(tbl[i].b_fe));
            chk($sformatf("vec%0d.b.fwd_ae", i), 8'(b_fa), 8'd0);
            chk($sformatf("vec%0d.b.fwd_be", i), 8'(b_fb), 8'd0);
            adv();
        end

        // Multi-cycle op: A released by done at t+5, B (bound 4) times out at t+4
        v = z; v.mce = 1; apply(v);
        settle();
        chk("mc.t0.a.stall_f", 8'(a_sf), 8'd1);
        chk("mc.t0.a.stall_e", 8'(a_se), 8'd1);
        chk("mc.t0.a.flush_m", 8'(a_fm), 8'd1);
        chk("mc.t0.a.busy", 8'(a_busy), 8'd0);
        chk("mc.t0.b.stall_e", 8'(b_se), 8'd1);
        adv();
        for (int k = 1; k <= 6; k++) begin
            v = z; v.mce = (k <= 5); v.done = (k == 5);
            if (k == 1) begin
                v.rse = 2'b01; v.rwe = 1; v.rde = 3; v.rs1d = 3;
            end
            apply(v);
            settle();
            if (k <= 4) begin
                chk($sformatf("mc.t%0d.a.stall_e", k), 8'(a_se), 8'd1);
                chk($sformatf("mc.t%0d.a.stall_d", k), 8'(a_sd), 8'd1);
                chk($sformatf("mc.t%0d.a.flush_m", k), 8'(a_fm), 8'd1);
                chk($sformatf("mc.t%0d.a.flush_e", k), 8'(a_fe), 8'd0);
                chk($sformatf("mc.t%0d.a.busy", k), 8'(a_busy), 8'd1);
                chk($sformatf("mc.t%0d.b.stall_e", k), 8'(b_se), 8'(k < 4));
                chk($sformatf("mc.t%0d.b.flush_e", k), 8'(b_fe), 8'd0);
                chk($sformatf("mc.t%0d.b.busy", k), 8'(b_busy), 8'd1);
                chk($sformatf("mc.t%0d.b.timeout", k), 8'(b_tmo), 8'd0);
            end else begin
                chk($sformatf("mc.t%0d.a.stall_e", k), 8'(a_se), 8'd0);
                chk($sformatf("mc.t%0d.a.stall_f", k), 8'(a_sf), 8'd0);
                chk($sformatf("mc.t%0d.a.flush_m", k), 8'(a_fm), 8'd0);
                chk($sformatf("mc.t%0d.b.stall_e", k), 8'(b_se), 8'd0);
                chk($sformatf("mc.t%0d.b.busy", k), 8'(b_busy), 8'd0);
                chk($sformatf("mc.t%0d.b.timeout", k), 8'(b_tmo), 8'd1);
                if (k == 6) chk("mc.t6.a.busy", 8'(a_busy), 8'd0);
            end
            adv();
        end

        // Zero-wait op, then a stray done while idle: neither may stall or start BUSY
        v = z; v.mce = 1; v.done = 1; apply(v);
        settle();
        chk("zw.a.stall_e", 8'(a_se), 8'd0);
        adv();
        v = z; v.done = 1; apply(v);
        settle();
        chk("zw.a.busy", 8'(a_busy), 8'd0);
        chk("stray.a.stall_e", 8'(a_se), 8'd0);
        adv();
        v = z; apply(v);
        settle();
        chk("stray.a.busy", 8'(a_busy), 8'd0);
        chk("sticky.b.timeout", 8'(b_tmo), 8'd1);
        chk("sticky.a.timeout", 8'(a_tmo), 8'd0);
        adv();
        v = z; v.rst = 1; apply(v);
        adv();
        v = z; apply(v);
        settle();
        chk("tmoclr.b.timeout", 8'(b_tmo), 8'd0);
        adv();

        // Reset asserted mid-BUSY
        v = z; v.mce = 1; apply(v);
        adv();
        settle();
        chk("rstbusy.a.busy_before", 8'(a_busy), 8'd1);
        adv();
        v.rst = 1; v.rwm = 1; v.rdm = 5; v.rs1e = 5; apply(v);
        settle();
        chk_out("rstbusy.a", get_out(0), '{0,0,0,1,1,1,2'b00,2'b00,1'b1,1'b0});
        adv();
        v = z; apply(v);
        settle();
        chk("rstbusy.a.busy_after", 8'(a_busy), 8'd0);
        chk("rstbusy.b.busy_after", 8'(b_busy), 8'd0);
        chk("rstbusy.a.stall_e", 8'(a_se), 8'd0);
        adv();

        // Load-use costs exactly one bubble
        v = z; v.rse = 2'b01; v.rwe = 1; v.rde = 3; v.rs1d = 3; apply(v);
        settle();
        chk("lu1.a.stall_d", 8'(a_sd), 8'd1);
        adv();
        v = z; v.rs1d = 3; v.rdm = 3; v.rwm = 1; apply(v);
        settle();
        chk("lu2.a.stall_d", 8'(a_sd), 8'd0);
        chk("lu2.a.flush_e", 8'(a_fe), 8'd0);
        adv();

        // No-forwarding build: one stall per stage the writer of x7 passes through
        for (int s = 0; s < 4; s++) begin
            v = z; v.rs1d = 7; v.rs1e = 7;
            if (s == 0) begin v.rde = 7; v.rwe = 1; end
            if (s == 1) begin v.rdm = 7; v.rwm = 1; end
            if (s == 2) begin v.rdw = 7; v.rww = 1; end
            apply(v);
            settle();
            chk($sformatf("nofwd%0d.b.stall_d", s), 8'(b_sd), 8'(s < 3));
            chk($sformatf("nofwd%0d.b.fwd_ae", s), 8'(b_fa), 8'd0);
            chk($sformatf("nofwd%0d.a.stall_d", s), 8'(a_sd), 8'd0);
            adv();
        end

        // Randomised run against the reference model
        v = z; v.rst = 1; apply(v);
        adv();
        model_step(v);
        for (int n = 0; n < 600; n++) begin
            v.rst  = ($urandom_range(0, 63) == 0);
            v.rs1d = 5'($urandom_range(0, 7)); v.rs2d = 5'($urandom_range(0, 7));
            v.rs1e = 5'($urandom_range(0, 7)); v.rs2e = 5'($urandom_range(0, 7));
            v.rde  = 5'($urandom_range(0, 7)); v.rdm  = 5'($urandom_range(0, 7));
            v.rdw  = 5'($urandom_range(0, 7));
            v.rwe  = 1'($urandom_range(0, 1)); v.rwm = 1'($urandom_range(0, 1));
            v.rww  = 1'($urandom_range(0, 1));
            v.rse  = 2'($urandom_range(0, 3));
            v.mce  = ($urandom_range(0, 2) == 0);
            v.done = ($urandom_range(0, 5) == 0);
            v.pc   = ($urandom_range(0, 7) == 0);
            apply(v);
            settle();
            chk_out($sformatf("rnd%0d.a", n), get_out(0), model_eval(v, 0));
            chk_out($sformatf("rnd%0d.b", n), get_out(1), model_eval(v, 1));
            @(posedge clk);
            model_step(v);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
